// File: rtl/mac_tx_arb.sv
// Two-port AXI4-Stream frame arbiter feeding the MAC TX byte stream.
// Grants are frame-locked; supports round-robin or fixed s0 priority, an inter-frame gap and frame counters.
module mac_tx_arb #(
  parameter int IFG_CYC   = 0,
  parameter int MAX_BEATS = 1536,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cfg_prio,
  input  logic             cnt_clr,
  input  logic [7:0]       s0_tdata,
  input  logic             s0_tvalid,
  input  logic             s0_tlast,
  output logic             s0_tready,
  input  logic [7:0]       s1_tdata,
  input  logic             s1_tvalid,
  input  logic             s1_tlast,
  output logic             s1_tready,
  output logic [7:0]       m_tdata,
  output logic             m_tvalid,
  output logic             m_tlast,
  input  logic             m_tready,
  output logic [1:0]       grant,
  output logic [CNT_W-1:0] frame_cnt0,
  output logic [CNT_W-1:0] frame_cnt1,
  output logic             err_long
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, GAP} state_e;

  localparam logic [10:0] MAX_B    = 11'(MAX_BEATS);
  localparam logic [7:0]  GAP_LAST = 8'(IFG_CYC - 1);

  state_e           state_q;
  logic [1:0]       grant_q;
  logic             rr_q;
  logic [7:0]       gap_q;
  logic [10:0]      beat_q;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic             err_q, err_d;
  logic             hs, last_hs;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [10:0] beat_inc(input logic [10:0] v);
    return (&v) ? v : v + 11'd1;
  endfunction

  // Zero-latency datapath steered by the registered grant
  assign m_tvalid  = (grant_q[0] & s0_tvalid) | (grant_q[1] & s1_tvalid);
  assign m_tdata   = grant_q[0] ? s0_tdata : (grant_q[1] ? s1_tdata : 8'h00);
  assign m_tlast   = (grant_q[0] & s0_tlast) | (grant_q[1] & s1_tlast);
  assign s0_tready = grant_q[0] & m_tready;
  assign s1_tready = grant_q[1] & m_tready;
  assign grant     = grant_q;
  assign frame_cnt0 = cnt0_q;
  assign frame_cnt1 = cnt1_q;
  assign err_long  = err_q;

  assign hs      = m_tvalid & m_tready;
  assign last_hs = hs & m_tlast;

  // Clear takes precedence over a same-cycle increment or error
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    err_d  = err_q;
    if (last_hs && grant_q[0]) cnt0_d = cnt_inc(cnt0_q);
    if (last_hs && grant_q[1]) cnt1_d = cnt_inc(cnt1_q);
    if (hs && !m_tlast && (beat_q >= MAX_B)) err_d = 1'b1;
    if (cnt_clr) begin
      cnt0_d = '0;
      cnt1_d = '0;
      err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      rr_q    <= 1'b0;
      gap_q   <= 8'd0;
      beat_q  <= 11'd0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
      err_q  <= err_d;
      case (state_q)
        IDLE: begin
          beat_q <= 11'd0;
          // rr_q set means s1 is owed the next tie
          if (s0_tvalid && (!s1_tvalid || cfg_prio || !rr_q)) begin
            state_q <= GNT0;
            grant_q <= 2'b01;
          end else if (s1_tvalid) begin
            state_q <= GNT1;
            grant_q <= 2'b10;
          end
        end
        GNT0, GNT1: begin
          if (hs) begin
            beat_q <= beat_inc(beat_q);
            if (m_tlast) begin
              rr_q    <= (state_q == GNT0);
              grant_q <= 2'b00;
              gap_q   <= 8'd0;
              state_q <= (IFG_CYC > 0) ? GAP : IDLE;
            end
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) state_q <= IDLE;
          else                   gap_q   <= gap_q + 8'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_tx_arb.sv
// Directed bench for mac_tx_arb: two instances (no gap and 12-cycle gap) share the stimulus;
// sel picks which instance drives the observed outputs and source handshakes.
module tb_mac_tx_arb;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cfg_prio, cnt_clr, m_tready;
  logic [7:0]  s0_tdata, s1_tdata;
  logic        s0_tvalid, s0_tlast, s1_tvalid, s1_tlast;

  logic        a_s0_tready, a_s1_tready, a_m_tvalid, a_m_tlast, a_err;
  logic [7:0]  a_m_tdata;
  logic [1:0]  a_grant;
  logic [15:0] a_cnt0, a_cnt1;
  logic        b_s0_tready, b_s1_tready, b_m_tvalid, b_m_tlast, b_err;
  logic [7:0]  b_m_tdata;
  logic [1:0]  b_grant;
  logic [15:0] b_cnt0, b_cnt1;

  logic        sel;
  logic        o_s0_tready, o_s1_tready, o_m_tvalid, o_m_tlast, o_err;
  logic [7:0]  o_m_tdata;
  logic [1:0]  o_grant;
  logic [15:0] o_cnt0, o_cnt1;

  always #5 clk = ~clk;

  mac_tx_arb #(.IFG_CYC(0), .MAX_BEATS(1536), .CNT_W(16)) u_a (
    .clk(clk), .rstn(rstn), .cfg_prio(cfg_prio), .cnt_clr(cnt_clr),
    .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(a_s0_tready),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(a_s1_tready),
    .m_tdata(a_m_tdata), .m_tvalid(a_m_tvalid), .m_tlast(a_m_tlast), .m_tready(m_tready),
    .grant(a_grant), .frame_cnt0(a_cnt0), .frame_cnt1(a_cnt1), .err_long(a_err));

  mac_tx_arb #(.IFG_CYC(12), .MAX_BEATS(1536), .CNT_W(16)) u_b (
    .clk(clk), .rstn(rstn), .cfg_prio(cfg_prio), .cnt_clr(cnt_clr),
    .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(b_s0_tready),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(b_s1_tready),
    .m_tdata(b_m_tdata), .m_tvalid(b_m_tvalid), .m_tlast(b_m_tlast), .m_tready(m_tready),
    .grant(b_grant), .frame_cnt0(b_cnt0), .frame_cnt1(b_cnt1), .err_long(b_err));

  assign o_s0_tready = sel ? b_s0_tready : a_s0_tready;
  assign o_s1_tready = sel ? b_s1_tready : a_s1_tready;
  assign o_m_tvalid  = sel ? b_m_tvalid  : a_m_tvalid;
  assign o_m_tlast   = sel ? b_m_tlast   : a_m_tlast;
  assign o_m_tdata   = sel ? b_m_tdata   : a_m_tdata;
  assign o_grant     = sel ? b_grant     : a_grant;
  assign o_cnt0      = sel ? b_cnt0      : a_cnt0;
  assign o_cnt1      = sel ? b_cnt1      : a_cnt1;
  assign o_err       = sel ? b_err       : a_err;

  int vectors, miscompares;
  int s0_nfr, s1_nfr, s0_len, s1_len, s0_idx, s1_idx;
  int rdy_mode, cyc, mac_idx, data_bad, stall_bad, s1_rdy_seen, first_beat_cyc;
  logic       prev_stall;
  logic [7:0] prev_data;
  int order[$];
  int frame_len[$];

  task automatic drive();
    s0_tvalid = (s0_nfr > 0);
    s0_tdata  = 8'(s0_idx);
    s0_tlast  = (s0_nfr > 0) && (s0_idx == s0_len - 1);
    s1_tvalid = (s1_nfr > 0);
    s1_tdata  = 8'h80 ^ 8'(s1_idx);
    s1_tlast  = (s1_nfr > 0) && (s1_idx == s1_len - 1);
    m_tready  = (rdy_mode == 0) ? 1'b1 : ((rdy_mode == 1) ? (cyc % 2 == 1) : 1'b0);
  endtask

  // One clock: apply stimulus, observe the MAC side, advance the source models
  task automatic step();
    int src;
    logic [7:0] exp;
    drive();
    #1;
    if (prev_stall && (o_m_tdata !== prev_data || o_m_tvalid !== 1'b1)) stall_bad++;
    prev_stall = o_m_tvalid & ~m_tready;
    prev_data  = o_m_tdata;
    if (o_s1_tready) s1_rdy_seen++;
    if (o_m_tvalid && m_tready) begin
      if (first_beat_cyc < 0) first_beat_cyc = cyc;
      src = (o_grant == 2'b10) ? 1 : 0;
      exp = (src == 1) ? (8'h80 ^ 8'(mac_idx)) : 8'(mac_idx);
      if (o_m_tdata !== exp) data_bad++;
      if (o_m_tlast) begin
        order.push_back(src);
        frame_len.push_back(mac_idx + 1);
        mac_idx = 0;
      end else mac_idx++;
    end
    if (s0_tvalid && o_s0_tready) begin
      if (s0_tlast) begin s0_nfr--; s0_idx = 0; end else s0_idx++;
    end
    if (s1_tvalid && o_s1_tready) begin
      if (s1_tlast) begin s1_nfr--; s1_idx = 0; end else s1_idx++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic reset_all(input logic which);
    sel = which;
    cfg_prio = 1'b0; cnt_clr = 1'b0; rdy_mode = 0;
    s0_nfr = 0; s1_nfr = 0; s0_len = 0; s1_len = 0; s0_idx = 0; s1_idx = 0;
    mac_idx = 0; data_bad = 0; stall_bad = 0; s1_rdy_seen = 0; first_beat_cyc = -1;
    prev_stall = 1'b0; prev_data = 8'h00;
    order.delete(); frame_len.delete();
    cyc = 0;
    drive();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    reset_all(1'b0);
    vectors++; if (o_grant !== 2'b00) begin miscompares++; $display("FAIL reset_grant: got %b want 00", o_grant); end
    vectors++; if ({o_m_tvalid, o_m_tlast, o_m_tdata} !== 10'd0) begin miscompares++; $display("FAIL reset_m: got %b/%b/%h want 0/0/00", o_m_tvalid, o_m_tlast, o_m_tdata); end
    vectors++; if ({o_s0_tready, o_s1_tready} !== 2'b00) begin miscompares++; $display("FAIL reset_tready: got %b want 00", {o_s0_tready, o_s1_tready}); end
    vectors++; if ({o_cnt0, o_cnt1, o_err} !== 33'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d/%0d/%b want 0/0/0", o_cnt0, o_cnt1, o_err); end
    vectors++; if ({b_grant, b_cnt0, b_err} !== 19'd0) begin miscompares++; $display("FAIL reset_gap_inst: got %b/%0d/%b want 00/0/0", b_grant, b_cnt0, b_err); end
  endtask

  task automatic test_single_frame();
    reset_all(1'b0);
    s0_nfr = 1; s0_len = 60;
    step();
    vectors++; if (o_grant !== 2'b01) begin miscompares++; $display("FAIL single_grant: got %b want 01", o_grant); end
    for (int i = 0; i < 200 && order.size() < 1; i++) step();
    vectors++; if (order.size() !== 1) begin miscompares++; $display("FAIL single_frames: got %0d want 1", order.size()); end
    else begin
      vectors++; if (frame_len[0] !== 60) begin miscompares++; $display("FAIL single_len: got %0d want 60", frame_len[0]); end
    end
    vectors++; if (data_bad !== 0) begin miscompares++; $display("FAIL single_data: got %0d bad bytes want 0", data_bad); end
    vectors++; if (first_beat_cyc !== 1) begin miscompares++; $display("FAIL single_latency: got %0d want 1", first_beat_cyc); end
    vectors++; if (o_cnt0 !== 16'd1) begin miscompares++; $display("FAIL single_cnt0: got %0d want 1", o_cnt0); end
    vectors++; if (o_grant !== 2'b00) begin miscompares++; $display("FAIL single_grant_end: got %b want 00", o_grant); end
  endtask

  task automatic test_round_robin();
    reset_all(1'b0);
    s0_nfr = 3; s0_len = 64; s1_nfr = 3; s1_len = 64;
    for (int i = 0; i < 600 && order.size() < 6; i++) step();
    vectors++; if (order.size() !== 6) begin miscompares++; $display("FAIL rr_frames: got %0d want 6", order.size()); end
    else begin
      for (int i = 0; i < 6; i++) begin
        vectors++; if (order[i] !== (i % 2)) begin miscompares++; $display("FAIL rr_order[%0d]: got s%0d want s%0d", i, order[i], i % 2); end
      end
    end
    vectors++; if (data_bad !== 0) begin miscompares++; $display("FAIL rr_data: got %0d bad bytes want 0", data_bad); end
    vectors++; if (cyc !== 390) begin miscompares++; $display("FAIL rr_cycles: got %0d want 390", cyc); end
    vectors++; if ({o_cnt0, o_cnt1} !== {16'd3, 16'd3}) begin miscompares++; $display("FAIL rr_cnt: got %0d/%0d want 3/3", o_cnt0, o_cnt1); end
  endtask

  task automatic test_fixed_prio();
    reset_all(1'b0);
    cfg_prio = 1'b1;
    s0_nfr = 4; s0_len = 10; s1_nfr = 1; s1_len = 10;
    for (int i = 0; i < 200 && order.size() < 4; i++) step();
    vectors++; if (order.size() !== 4 || order.sum() !== 0) begin miscompares++; $display("FAIL prio_order: got %0d frames, %0d from s1, want 4, 0", order.size(), order.sum()); end
    vectors++; if (s1_rdy_seen !== 0) begin miscompares++; $display("FAIL prio_s1_tready: got %0d cycles want 0", s1_rdy_seen); end
    vectors++; if (o_grant !== 2'b00) begin miscompares++; $display("FAIL prio_idle: got %b want 00", o_grant); end
    step();
    vectors++; if (o_grant !== 2'b10) begin miscompares++; $display("FAIL prio_s1_grant: got %b want 10", o_grant); end
    for (int i = 0; i < 50 && order.size() < 5; i++) step();
    vectors++; if ({o_cnt0, o_cnt1} !== {16'd4, 16'd1}) begin miscompares++; $display("FAIL prio_cnt: got %0d/%0d want 4/1", o_cnt0, o_cnt1); end
  endtask

  task automatic test_ifg_stall();
    int n;
    reset_all(1'b1);
    rdy_mode = 1;
    s0_nfr = 2; s0_len = 100;
    for (int i = 0; i < 400 && order.size() < 1; i++) step();
    vectors++; if (order.size() !== 1 || frame_len[0] !== 100) begin miscompares++; $display("FAIL ifg_frame: got %0d frames want 1 of 100", order.size()); end
    n = 0;
    while (o_grant === 2'b00 && n < 50) begin step(); n++; end
    vectors++; if (n !== 13) begin miscompares++; $display("FAIL ifg_gap: got %0d idle cycles want 13 (12 gap + 1 idle)", n); end
    vectors++; if (o_grant !== 2'b01) begin miscompares++; $display("FAIL ifg_regrant: got %b want 01", o_grant); end
    vectors++; if (stall_bad !== 0 || data_bad !== 0) begin miscompares++; $display("FAIL ifg_stable: got %0d stall / %0d data errors want 0/0", stall_bad, data_bad); end
  endtask

  task automatic test_long_frame();
    reset_all(1'b0);
    s1_nfr = 1; s1_len = 1536;
    for (int i = 0; i < 1700 && order.size() < 1; i++) step();
    vectors++; if (o_err !== 1'b0 || o_cnt1 !== 16'd1) begin miscompares++; $display("FAIL long_1536: got err %b cnt1 %0d want 0/1", o_err, o_cnt1); end
    s1_nfr = 1; s1_len = 1600;
    for (int i = 0; i < 1700 && order.size() < 2; i++) step();
    vectors++; if (o_err !== 1'b1) begin miscompares++; $display("FAIL long_err: got %b want 1", o_err); end
    vectors++; if (order.size() !== 2 || frame_len[1] !== 1600) begin miscompares++; $display("FAIL long_len: got %0d frames want 2 (last 1600)", order.size()); end
    repeat (5) step();
    vectors++; if (o_err !== 1'b1 || o_cnt1 !== 16'd2) begin miscompares++; $display("FAIL long_sticky: got err %b cnt1 %0d want 1/2", o_err, o_cnt1); end
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    vectors++; if ({o_err, o_cnt0, o_cnt1} !== 33'd0) begin miscompares++; $display("FAIL long_clr: got %b/%0d/%0d want 0/0/0", o_err, o_cnt0, o_cnt1); end
    cnt_clr = 1'b1;
    s0_nfr = 1; s0_len = 4;
    for (int i = 0; i < 20 && order.size() < 3; i++) step();
    cnt_clr = 1'b0;
    vectors++; if (order.size() !== 3 || o_cnt0 !== 16'd0) begin miscompares++; $display("FAIL clr_wins: got %0d frames cnt0 %0d want 3/0", order.size(), o_cnt0); end
  endtask

  task automatic test_reset_midframe();
    reset_all(1'b0);
    s0_nfr = 1; s0_len = 60;
    for (int i = 0; i < 100 && s0_idx < 30; i++) step();
    vectors++; if (o_m_tvalid !== 1'b1) begin miscompares++; $display("FAIL mid_active: got m_tvalid %b want 1", o_m_tvalid); end
    rstn = 1'b0;
    #1;
    vectors++; if ({o_grant, o_m_tvalid, o_m_tlast, o_m_tdata, o_s0_tready} !== 13'd0) begin miscompares++; $display("FAIL mid_async: got grant %b vld %b data %h rdy %b want all 0", o_grant, o_m_tvalid, o_m_tdata, o_s0_tready); end
    vectors++; if (o_cnt0 !== 16'd0) begin miscompares++; $display("FAIL mid_cnt0: got %0d want 0", o_cnt0); end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    s0_idx = 0; s0_nfr = 1; mac_idx = 0; cyc = 0; first_beat_cyc = -1;
    for (int i = 0; i < 200 && order.size() < 1; i++) step();
    vectors++; if (order.size() !== 1 || frame_len[0] !== 60 || data_bad !== 0) begin miscompares++; $display("FAIL mid_recover: got %0d frames, %0d bad bytes want 1 clean frame", order.size(), data_bad); end
    vectors++; if (o_cnt0 !== 16'd1 || first_beat_cyc !== 1) begin miscompares++; $display("FAIL mid_regrant: got cnt0 %0d latency %0d want 1/1", o_cnt0, first_beat_cyc); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_fixed_prio();
    test_ifg_stall();
    test_long_frame();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
